// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset core: sequences fetch,
// decode, execute, memory and writeback, driving all datapath enables/muxes.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam int unsigned OP_W = 6;
    localparam int unsigned ST_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t cur, nxt;

    assign state = ST_W'(cur);

    // State register; reset drops every enable asynchronously via IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_IDLE;
        else        cur <= nxt;
    end

    // Next-state and Moore/Mealy output decode.
    always_comb begin
        nxt        = S_IDLE;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (cur)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    nxt      = S_DECODE;
                end else begin
                    nxt = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:    nxt = S_MEMADR;
                    OP_RTYPE:        nxt = S_EXEC;
                    OP_BEQ, OP_BNE:  nxt = S_BRANCH;
                    OP_ADDI:         nxt = S_ADDIEX;
                    OP_J:            nxt = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                nxt      = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end else begin
                    nxt = S_MEMWR;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_BRANCH: begin
                // Opcode is held by the IR, so BEQ/BNE is resolved directly.
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_source  = 2'b01;
                instr_done = 1'b1;
                pc_en      = (opcode == OP_BNE) ? ~zero : zero;
                nxt        = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors push
// hand-computed output words; a negedge monitor pops and compares them.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // Word layout: state | pc_en i_or_d mem_read mem_write ir_write
    //              mem_to_reg reg_dst reg_write alu_src_a | alu_src_b |
    //              alu_op | pc_source | instr_done illegal_op
    localparam logic [20:0] X_IDLE    = {4'd0,  9'b0_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] X_FETCH_W = {4'd1,  9'b0_0_1_0_0_0_0_0_0, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] X_FETCH_R = {4'd1,  9'b1_0_1_0_1_0_0_0_0, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] X_DECODE  = {4'd2,  9'b0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] X_DEC_ILL = {4'd2,  9'b0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 2'b00, 2'b11};
    localparam logic [20:0] X_MEMADR  = {4'd3,  9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] X_MEMRD   = {4'd4,  9'b0_1_1_0_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] X_MEMWB   = {4'd5,  9'b0_0_0_0_0_1_0_1_0, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [20:0] X_MEMWR_W = {4'd6,  9'b0_1_0_1_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] X_MEMWR_R = {4'd6,  9'b0_1_0_1_0_0_0_0_0, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [20:0] X_EXEC    = {4'd7,  9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b10, 2'b00, 2'b00};
    localparam logic [20:0] X_ALUWB   = {4'd8,  9'b0_0_0_0_0_0_1_1_0, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [20:0] X_ADDIEX  = {4'd9,  9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 2'b00, 2'b00};
    localparam logic [20:0] X_ADDIWB  = {4'd10, 9'b0_0_0_0_0_0_0_1_0, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [20:0] X_BR_T    = {4'd11, 9'b1_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 2'b01, 2'b10};
    localparam logic [20:0] X_BR_NT   = {4'd11, 9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b01, 2'b01, 2'b10};
    localparam logic [20:0] X_JUMP    = {4'd12, 9'b1_0_0_0_0_0_0_0_0, 2'b00, 2'b00, 2'b10, 2'b10};

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

    typedef struct {
        string       name;
        logic [20:0] exp;
    } item_t;

    item_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Drive one cycle of inputs and queue the output word expected during it.
    task automatic apply(input string name, input logic rst, input logic [5:0] op,
                         input logic mr, input logic z, input logic [20:0] exp);
        item_t it;
        rst_n     = rst;
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        it.name   = name;
        it.exp    = exp;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the live output word against the scoreboard head.
    always @(negedge clk) begin
        item_t       it;
        logic [20:0] act;
        if (sb.size() != 0) begin
            it  = sb.pop_front();
            act = {state, pc_en, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                   alu_op, pc_source, instr_done, illegal_op};
            n_vec++;
            if (act !== it.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    initial begin
        rst_n = 1'b0; opcode = RT; mem_ready = 1'b1; zero = 1'b0;
        @(posedge clk);
        #1;
        apply("reset0", 1'b0, RT, 1'b1, 1'b0, X_IDLE);
        apply("reset1", 1'b0, RT, 1'b1, 1'b0, X_IDLE);
        apply("idle_ignores_ready", 1'b1, RT, 1'b1, 1'b0, X_IDLE);

        apply("rt_fetch",  1'b1, RT, 1'b1, 1'b0, X_FETCH_R);
        apply("rt_decode", 1'b1, RT, 1'b1, 1'b0, X_DECODE);
        apply("rt_exec",   1'b1, RT, 1'b1, 1'b0, X_EXEC);
        apply("rt_aluwb",  1'b1, RT, 1'b1, 1'b0, X_ALUWB);

        apply("addi_fetch",  1'b1, ADDI, 1'b1, 1'b0, X_FETCH_R);
        apply("addi_decode", 1'b1, ADDI, 1'b1, 1'b0, X_DECODE);
        apply("addi_ex",     1'b1, ADDI, 1'b1, 1'b0, X_ADDIEX);
        apply("addi_wb",     1'b1, ADDI, 1'b1, 1'b0, X_ADDIWB);

        apply("lw_fetch_w0", 1'b1, LW, 1'b0, 1'b0, X_FETCH_W);
        apply("lw_fetch_w1", 1'b1, LW, 1'b0, 1'b0, X_FETCH_W);
        apply("lw_fetch_r",  1'b1, LW, 1'b1, 1'b0, X_FETCH_R);
        apply("lw_decode",   1'b1, LW, 1'b0, 1'b0, X_DECODE);
        apply("lw_memadr",   1'b1, LW, 1'b0, 1'b0, X_MEMADR);
        apply("lw_memrd_w0", 1'b1, LW, 1'b0, 1'b0, X_MEMRD);
        apply("lw_memrd_w1", 1'b1, LW, 1'b0, 1'b0, X_MEMRD);
        apply("lw_memrd_w2", 1'b1, LW, 1'b0, 1'b0, X_MEMRD);
        apply("lw_memrd_r",  1'b1, LW, 1'b1, 1'b0, X_MEMRD);
        apply("lw_memwb",    1'b1, LW, 1'b1, 1'b0, X_MEMWB);

        apply("beq_z1_fetch",  1'b1, BEQ, 1'b1, 1'b1, X_FETCH_R);
        apply("beq_z1_decode", 1'b1, BEQ, 1'b1, 1'b1, X_DECODE);
        apply("beq_z1_branch", 1'b1, BEQ, 1'b1, 1'b1, X_BR_T);
        apply("bne_z1_fetch",  1'b1, BNE, 1'b1, 1'b1, X_FETCH_R);
        apply("bne_z1_decode", 1'b1, BNE, 1'b1, 1'b1, X_DECODE);
        apply("bne_z1_branch", 1'b1, BNE, 1'b1, 1'b1, X_BR_NT);
        apply("beq_z0_fetch",  1'b1, BEQ, 1'b1, 1'b0, X_FETCH_R);
        apply("beq_z0_decode", 1'b1, BEQ, 1'b1, 1'b0, X_DECODE);
        apply("beq_z0_branch", 1'b1, BEQ, 1'b1, 1'b0, X_BR_NT);
        apply("bne_z0_fetch",  1'b1, BNE, 1'b1, 1'b0, X_FETCH_R);
        apply("bne_z0_decode", 1'b1, BNE, 1'b1, 1'b0, X_DECODE);
        apply("bne_z0_branch", 1'b1, BNE, 1'b1, 1'b0, X_BR_T);

        apply("sw_fetch",    1'b1, SW, 1'b1, 1'b0, X_FETCH_R);
        apply("sw_decode",   1'b1, SW, 1'b1, 1'b0, X_DECODE);
        apply("sw_memadr",   1'b1, SW, 1'b1, 1'b0, X_MEMADR);
        apply("sw_memwr_w0", 1'b1, SW, 1'b0, 1'b0, X_MEMWR_W);
        apply("sw_memwr_w1", 1'b1, SW, 1'b0, 1'b0, X_MEMWR_W);
        apply("sw_memwr_w2", 1'b1, SW, 1'b0, 1'b0, X_MEMWR_W);
        apply("sw_memwr_w3", 1'b1, SW, 1'b0, 1'b0, X_MEMWR_W);
        apply("sw_memwr_r",  1'b1, SW, 1'b1, 1'b0, X_MEMWR_R);

        apply("ill_fetch",  1'b1, BAD, 1'b1, 1'b0, X_FETCH_R);
        apply("ill_decode", 1'b1, BAD, 1'b1, 1'b0, X_DEC_ILL);
        apply("j_fetch",    1'b1, JMP, 1'b1, 1'b0, X_FETCH_R);
        apply("j_decode",   1'b1, JMP, 1'b1, 1'b0, X_DECODE);
        apply("j_jump",     1'b1, JMP, 1'b1, 1'b0, X_JUMP);

        apply("rst_lw_fetch",  1'b1, LW, 1'b1, 1'b0, X_FETCH_R);
        apply("rst_lw_decode", 1'b1, LW, 1'b1, 1'b0, X_DECODE);
        apply("rst_lw_memadr", 1'b1, LW, 1'b1, 1'b0, X_MEMADR);
        apply("rst_lw_memrd",  1'b1, LW, 1'b0, 1'b0, X_MEMRD);
        apply("rst_async",     1'b0, LW, 1'b1, 1'b0, X_IDLE);
        apply("rst_hold",      1'b0, LW, 1'b1, 1'b0, X_IDLE);
        apply("rst_rel_idle",  1'b1, LW, 1'b0, 1'b0, X_IDLE);
        apply("rst_rel_fetch", 1'b1, LW, 1'b0, 1'b0, X_FETCH_W);

        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS-subset core.
- Sequences fetch, decode, execute, memory and writeback over a shared memory port and a single ALU.
- Drives all datapath enables and muxes, and supplies the 2-bit ALUOp to the ALU-control decoder. ALUOp 00 = add, 01 = sub, 10 = R-type funct decode.
- Waits on a memory ready handshake; evaluates branch conditions from the ALU zero flag.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_BNE, 6'b000101, branch if not equal
- OP_ADDI, 6'b001000, add immediate
- OP_J, 6'b000010, jump

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag, combinational from current ALU operation
- mem_ready  in  1  memory completes the current access this cycle
- pc_en  out  1  PC register write enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write data select: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  destination register select: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  to ALU-control decoder
- pc_source  out  2  PC mux: 00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- Outputs are combinational from state (plus mem_ready and zero where noted). Every output not listed for a state is 0.
- The state register is the only sequential element.
- Reset (rst_n=0, async): state = IDLE. All outputs are 0, including state=0.
- IDLE: all outputs 0. Next state is FETCH unconditionally on the first clock after reset release.
- FETCH: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - While mem_ready=0: hold in FETCH with mem_read still 1; ir_write=0 and pc_en=0.
  - When mem_ready=1: ir_write=1, pc_en=1, next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ/BNE -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 and instr_done=1 this cycle and no writes.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: i_or_d=1, mem_read=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEMWR: i_or_d=1, mem_write=1. Hold until mem_ready=1; on that cycle instr_done=1, next state FETCH. mem_write stays asserted for the whole hold.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, instr_done=1. Next state FETCH.
  - pc_en = zero for BEQ, ~zero for BNE.
  - opcode is held stable by the IR, so it is sampled directly here.
- JUMP: pc_source=10, pc_en=1, instr_done=1. Next state FETCH.
- Latency with mem_ready always 1:
  - R-type 4, ADDI 4, LW 5, SW 4, BEQ/BNE 3, J 3 cycles.
  - Each mem_ready=0 cycle adds one cycle in FETCH, MEMRD or MEMWR.
- Boundaries:
  - mem_ready asserted in a state that does not access memory is ignored.
  - Reset asserted mid-instruction forces IDLE immediately: no partial writes complete and all enables drop asynchronously.
  - Illegal state encodings go to IDLE.
  - At most one of mem_read/mem_write is asserted in any cycle.
  - reg_write and pc_en are never asserted together except in FETCH (where reg_write=0).

Test Plan:
- Reset pulse mid-MEMRD -> all outputs 0 immediately and state=IDLE; after release, IDLE one cycle, then FETCH with mem_read=1.
- R-type 000000, mem_ready=1 -> states FETCH, DECODE, EXEC, ALUWB; alu_op=10 in EXEC; reg_write=1, reg_dst=1 in ALUWB; instr_done pulses once after 4 cycles.
- LW 100011 with mem_ready low 2 cycles in FETCH and 3 cycles in MEMRD -> 10 cycles total; ir_write and pc_en high only on the FETCH ready cycle; mem_to_reg=1 in MEMWB.
- BEQ with zero=1 -> pc_en=1, pc_source=01, alu_op=01 in BRANCH; BNE with zero=1 -> pc_en=0; each takes 3 cycles.
- SW with mem_ready=0 for 4 cycles in MEMWR -> mem_write held high 5 cycles, never with mem_read; instr_done on the ready cycle.
- Opcode 111111 -> illegal_op and instr_done pulse in DECODE, no reg_write/mem_write, back to FETCH; then J 000010 -> pc_source=10, pc_en=1 in JUMP.
